tb_rd_seq: RTL

- Read sequencer for the TB buffer bank, directly upstream of the TB read-data mapper.
- Accepts one read command at a time and issues L-wide row reads (TB_ena/TB_addra) for it.
- Delays the mapper controls (TB_douta_sel, l_k_0) by the BRAM read latency, so they reach the mapper in the same cycle as the matching TB_douta.
- Flags the registered mapper output as valid one cycle later and pulses done when the command completes.

---
 rtl/tb_rd_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tb_rd_seq.sv
// TB read sequencer: issues one command's row reads on TB port a and delays the
// mapper controls by the BRAM read latency so they line up with TB_douta.
module tb_rd_seq #(
  parameter int X        = 4,
  parameter int L        = 4,
  parameter int RSA_DW   = 16,
  parameter int TB_AW    = 10,
  parameter int RD_DELAY = 2
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [TB_AW-1:0] cmd_base_addr,
  input  logic [7:0]       cmd_len,
  input  logic             cmd_addr_dec,
  input  logic             cmd_dest,
  input  logic [1:0]       cmd_dir,
  input  logic             cmd_l_k_0,
  output logic             TB_ena,
  output logic [TB_AW-1:0] TB_addra,
  output logic [2:0]       TB_douta_sel,
  output logic             l_k_0,
  output logic             map_valid,
  output logic             busy,
  output logic             done
);

  if (X < 1 || L < 1 || RSA_DW < 1 || TB_AW < 1 || RD_DELAY < 1 || RD_DELAY > 4) begin : g_param_check
    $error("tb_rd_seq: illegal parameter value");
  end

  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_ISSUE  = 2'd1;
  localparam logic [1:0]       S_DRAIN  = 2'd2;
  localparam logic [TB_AW-1:0] ADDR_ONE = {{(TB_AW-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [TB_AW-1:0] r_addr;
  logic [7:0]       r_left;
  logic             r_dec;
  logic             r_dest;
  logic [1:0]       r_dir;
  logic             r_lk;
  logic [RD_DELAY-1:0] r_pv;
  logic [RD_DELAY-1:0] r_pdest;
  logic [RD_DELAY-1:0] r_plk;
  logic [1:0]          r_pdir [RD_DELAY];
  logic             r_map_valid;

  logic w_accept;
  logic w_issue;
  logic w_pipe_empty;
  logic w_tail_v;

  assign w_accept     = cmd_valid && (r_state == S_IDLE);
  assign w_issue      = (r_state == S_ISSUE);
  assign w_pipe_empty = ~|r_pv;
  assign w_tail_v     = r_pv[RD_DELAY-1];

  // Command FSM and address generator
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_left  <= '0;
      r_dec   <= 1'b0;
      r_dest  <= 1'b0;
      r_dir   <= 2'b00;
      r_lk    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= cmd_base_addr;
            r_left  <= cmd_len;
            r_dec   <= cmd_addr_dec;
            r_dest  <= cmd_dest;
            r_dir   <= cmd_dir;
            r_lk    <= cmd_l_k_0;
            r_state <= (cmd_len == 8'd0) ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_addr <= r_dec ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
          r_left <= r_left - 8'd1;
          if (r_left == 8'd1) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pipe_empty) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Control pipeline matching the BRAM read latency; stage 0 is loaded with the issue slot
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_pv        <= '0;
      r_pdest     <= '0;
      r_plk       <= '0;
      r_map_valid <= 1'b0;
      for (int i = 0; i < RD_DELAY; i++) begin
        r_pdir[i] <= 2'b00;
      end
    end else begin
      r_pv[0]     <= w_issue;
      r_pdest[0]  <= r_dest;
      r_plk[0]    <= r_lk;
      r_pdir[0]   <= r_dir;
      for (int i = 1; i < RD_DELAY; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_pdest[i] <= r_pdest[i-1];
        r_plk[i]   <= r_plk[i-1];
        r_pdir[i]  <= r_pdir[i-1];
      end
      r_map_valid <= w_tail_v;
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign TB_ena       = w_issue;
  assign TB_addra     = r_addr;
  // An empty tail slot forces select 000, which zeroes the mapper outputs
  assign TB_douta_sel = w_tail_v ? {r_pdest[RD_DELAY-1], r_pdir[RD_DELAY-1]} : 3'b000;
  assign l_k_0        = w_tail_v & r_plk[RD_DELAY-1];
  assign map_valid    = r_map_valid;
  assign done         = (r_state == S_DRAIN) && w_pipe_empty;

endmodule
